// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and default operand width.
package alu_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus of the sequential divider.
interface seq_divider_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, restore on borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] sub_b;
  logic [WIDTH:0] diff;
  logic           brw;
  // R < D holds between steps, so the top bit of R is always clear here.
  logic           unused_r_msb;

  assign unused_r_msb = r_i[WIDTH];
  assign r_sh  = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign sub_b = {1'b0, d_i};

  always_comb begin
    diff = '0;
    brw  = 1'b0;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      diff[i] = r_sh[i] ^ sub_b[i] ^ brw;
      brw     = (~r_sh[i] & sub_b[i]) | (~(r_sh[i] ^ sub_b[i]) & brw);
    end
  end

  assign r_o = brw ? r_sh : diff;
  assign q_o = {q_i[WIDTH-2:0], ~brw};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (sign fix-up in the result stage).
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_t state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   r_q, r_nxt;
  logic [WIDTH-1:0] q_q, q_nxt, d_q;
  logic             zero_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_q;
  logic             accept, last;
  logic [WIDTH-1:0] dvd_ld, dvs_ld, quot_d, rem_d;

  assign accept = bus.start && (state_q != StRun);
  // A zero divisor spends a single cycle in RUN and finishes without iterating.
  assign last   = (state_q == StRun) && (zero_q || (cnt_q == LastCnt));

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(d_q),
    .r_o(r_nxt),
    .q_o(q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = accept ? StRun : StIdle;
      StRun:          if (last) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_r_q;

  always_comb begin
    // Raw dividend is kept for divide-by-zero so it can be returned as the remainder.
    if (bus.divisor == '0) begin
      dvd_ld = bus.dividend;
    end else begin
      dvd_ld = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    end
    dvs_ld = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    quot_d = zero_q ? '1 : (neg_q_q ? -q_nxt : q_nxt);
    rem_d  = zero_q ? q_q : (neg_r_q ? -r_nxt[WIDTH-1:0] : r_nxt[WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r_q <= bus.dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    dvd_ld = bus.dividend;
    dvs_ld = bus.divisor;
    quot_d = zero_q ? '1 : q_nxt;
    rem_d  = zero_q ? q_q : r_nxt[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      zero_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= dvd_ld;
      d_q    <= dvs_ld;
      zero_q <= (bus.divisor == '0);
    end else if (state_q == StRun) begin
      cnt_q <= cnt_q + CntW'(1);
      r_q   <= r_nxt;
      q_q   <= q_nxt;
      if (last) begin
        quot_q <= quot_d;
        rem_q  <= rem_d;
        dbz_q  <= zero_q;
      end
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32); honours SEQ_DIVIDER_SIGNED_EN for the sign vectors.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after done has dropped.
  task automatic do_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input int lat, input int glitch);
    int n;
    int busy_n;
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    @(posedge clk);
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = 32'h0000_dead;
    dif.divisor  = 32'h0;
    n      = 0;
    busy_n = 0;
    while (dif.done !== 1'b1 && n < 200) begin
      if (dif.busy === 1'b1) busy_n++;
      if (n == glitch) begin
        dif.start    = 1'b1;
        dif.dividend = 32'd9;
        dif.divisor  = 32'd3;
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    dif.start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(lat));
    check({tag, " busy at done"}, 64'(dif.busy), 64'(0));
    check({tag, " quotient"}, 64'(dif.quotient), 64'(eq));
    check({tag, " remainder"}, 64'(dif.remainder), 64'(er));
    check({tag, " dbz"}, 64'(dif.div_by_zero), 64'(ez));
    @(negedge clk);
    check({tag, " done single"}, 64'(dif.done), 64'(0));
    check({tag, " quotient held"}, 64'(dif.quotient), 64'(eq));
  endtask

  initial begin
    int n;
    int seen;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(dif.busy), 64'(0));
    check("reset done", 64'(dif.done), 64'(0));
    check("reset quotient", 64'(dif.quotient), 64'(0));
    check("reset remainder", 64'(dif.remainder), 64'(0));
    check("reset dbz", 64'(dif.div_by_zero), 64'(0));

    do_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, -1);
    do_op("max/1", 32'hffff_ffff, 32'd1, 32'hffff_ffff, 32'd0, 1'b0, 32, -1);
    do_op("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32, -1);
`ifdef SEQ_DIVIDER_SIGNED_EN
    do_op("-7/2", 32'hffff_fff9, 32'd2, 32'hffff_fffd, 32'hffff_ffff, 1'b0, 32, -1);
    do_op("ovf", 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'd0, 1'b0, 32, -1);
`else
    do_op("fff9/2", 32'hffff_fff9, 32'd2, 32'h7fff_fffc, 32'd1, 1'b0, 32, -1);
    do_op("8000/ffff", 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 1'b0, 32, -1);
`endif
    do_op("42/0", 32'd42, 32'd0, 32'hffff_ffff, 32'd42, 1'b1, 1, -1);

    // Reset ten cycles into RUN: everything clears and no done follows.
    dif.start    = 1'b1;
    dif.dividend = 32'd100;
    dif.divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", 64'(dif.busy), 64'(0));
    check("rst done", 64'(dif.done), 64'(0));
    check("rst quotient", 64'(dif.quotient), 64'(0));
    check("rst remainder", 64'(dif.remainder), 64'(0));
    check("rst dbz", 64'(dif.div_by_zero), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done === 1'b1) seen++;
    end
    check("rst no done", 64'(seen), 64'(0));
    do_op("after rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, -1);

    do_op("glitch", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 5);

    // start held high through RUN and DONE: second op follows back-to-back.
    dif.start    = 1'b1;
    dif.dividend = 32'd100;
    dif.divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    dif.dividend = 32'd5;
    dif.divisor  = 32'd9;
    n = 0;
    while (dif.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", 64'(n), 64'(32));
    check("b2b first quotient", 64'(dif.quotient), 64'(14));
    check("b2b first remainder", 64'(dif.remainder), 64'(2));
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    check("b2b second busy", 64'(dif.busy), 64'(1));
    n = 0;
    while (dif.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b second latency", 64'(n), 64'(32));
    check("b2b second quotient", 64'(dif.quotient), 64'(0));
    check("b2b second remainder", 64'(dif.remainder), 64'(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
